led_chase_ctrl: RTL

//  Sequencer that schedules one fixed-window LED pulse across N_LED outputs in turn (chase pattern).

---
 rtl/led_chase_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/led_chase_ctrl.sv
// Chase sequencer: one LED at a time is pulsed inside a fixed window of each PERIOD-clock step.
// Steps run upward or downward, single pass or looping, under START/STOP control.
module led_chase_ctrl #(
   parameter int unsigned N_LED    = 4,
   parameter int unsigned CNT_W    = 23,
   parameter int unsigned PERIOD   = 5_000_000,
   parameter int unsigned ON_START = 2_500_000,
   parameter int unsigned ON_END   = 3_750_000
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     i_start,
   input  logic                     i_stop,
   input  logic                     i_dir,
   input  logic                     i_loop,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [$clog2(N_LED)-1:0] o_step_idx,
   output logic [N_LED-1:0]         o_led_out
);

   localparam int unsigned IDX_W = $clog2(N_LED);

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] LP_ON_S     = CNT_W'(ON_START);
   localparam logic [CNT_W-1:0] LP_ON_E     = CNT_W'(ON_END);
   localparam logic [IDX_W-1:0] LP_IDX_TOP  = IDX_W'(N_LED - 1);

   typedef enum logic {StIdle, StRun} state_e;

   state_e            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_step;
   logic              r_dir;
   logic              r_loop;
   logic              r_busy;
   logic              r_done;
   logic [N_LED-1:0]  r_led;

   logic              w_in_win;
   logic              w_cnt_last;
   logic              w_step_last;
   logic [IDX_W-1:0]  w_step_first;
   logic [IDX_W-1:0]  w_step_next;
   logic [N_LED-1:0]  w_onehot;

   assign w_in_win     = (r_cnt >= LP_ON_S) && (r_cnt < LP_ON_E);
   assign w_cnt_last   = (r_cnt == LP_CNT_LAST);
   assign w_step_last  = r_dir ? (r_step == '0) : (r_step == LP_IDX_TOP);
   assign w_step_first = r_dir ? LP_IDX_TOP : '0;
   assign w_step_next  = r_dir ? (r_step - IDX_W'(1)) : (r_step + IDX_W'(1));
   assign w_onehot     = {{(N_LED-1){1'b0}}, 1'b1} << r_step;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_step  <= '0;
         r_dir   <= 1'b0;
         r_loop  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_led   <= '0;
      end else begin
         r_done <= 1'b0;
         r_led  <= '0;
         unique case (r_state)
            StIdle: begin
               // STOP wins over a simultaneous START
               if (i_start && !i_stop) begin
                  r_state <= StRun;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_step  <= i_dir ? LP_IDX_TOP : '0;
                  r_dir   <= i_dir;
                  r_loop  <= i_loop;
               end
            end
            StRun: begin
               if (i_stop) begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
                  r_step  <= '0;
               end else begin
                  if (w_in_win) begin
                     r_led <= w_onehot;
                  end
                  if (w_cnt_last) begin
                     r_cnt <= '0;
                     if (!w_step_last) begin
                        r_step <= w_step_next;
                     end else if (r_loop) begin
                        r_step <= w_step_first;
                     end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_step  <= '0;
                        r_done  <= 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_step_idx = r_step;
   assign o_led_out  = r_led;

endmodule
